vx_tl_req_arbiter: RTL and testbench

VX_TL_REQ_ARBITER -- requirements
Module: vx_tl_req_arbiter

---
 rtl/vx_tl_req_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_vx_tl_req_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tl_req_arbiter.sv
// rtl/vx_tl_req_arbiter.sv - round-robin TL-A request arbiter with D-channel response routing
// Optional per-requester perf counters when VX_TL_ARB_PERF_EN is defined.
module vx_tl_req_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int MAX_OUT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [3*NUM_REQ-1:0]    req_opcode,
    input  logic [10*NUM_REQ-1:0]   req_source,
    input  logic [32*NUM_REQ-1:0]   req_address,
    input  logic [32*NUM_REQ-1:0]   req_data,
    input  logic [4*NUM_REQ-1:0]    req_mask,
    output logic                    a_valid,
    output logic [2:0]              a_opcode,
    output logic [3:0]              a_size,
    output logic [9:0]              a_source,
    output logic [31:0]             a_address,
    output logic [31:0]             a_data,
    output logic [3:0]              a_mask,
    input  logic                    a_ready,
    input  logic                    d_valid,
    input  logic [2:0]              d_opcode,
    input  logic [9:0]              d_source,
    input  logic [31:0]             d_data,
    output logic                    d_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [2:0]              rsp_opcode,
    output logic [9:0]              rsp_source,
    output logic [31:0]             rsp_data,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic                    err_bad_source
`ifdef VX_TL_ARB_PERF_EN
    ,
    output logic [32*NUM_REQ-1:0]   perf_grants,
    output logic [32*NUM_REQ-1:0]   perf_stalls
`endif
);

    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [3:0]         out_cnt_q [NUM_REQ];
    logic [3:0]         out_cnt_d [NUM_REQ];
    logic               a_valid_q, a_valid_d;
    logic [2:0]         a_opcode_q, a_opcode_d;
    logic [9:0]         a_source_q, a_source_d;
    logic [31:0]        a_address_q, a_address_d;
    logic [31:0]        a_data_q, a_data_d;
    logic [3:0]         a_mask_q, a_mask_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] eligible;
    logic               grant_found;
    logic [2:0]         grant_idx;
    logic               grant;
    logic [2:0]         d_id;
    logic               d_id_ok;
    logic               d_ready_sel;
    logic               d_fire;

    function automatic logic [2:0] rr_idx(input logic [2:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return 3'(s);
    endfunction

    // First eligible requester at or after rr_ptr wins.
    always_comb begin
        eligible    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (out_cnt_q[i] < 4'(MAX_OUT));
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && eligible[rr_idx(rr_ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx(rr_ptr_q, k);
            end
        end
        grant = grant_found && (!a_valid_q || a_ready) && !reset;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (grant_idx == 3'(i));
        end
    end

    always_comb begin
        a_valid_d   = a_valid_q && !a_ready;
        a_opcode_d  = a_opcode_q;
        a_source_d  = a_source_q;
        a_address_d = a_address_q;
        a_data_d    = a_data_q;
        a_mask_d    = a_mask_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant) begin
            a_valid_d   = 1'b1;
            a_opcode_d  = req_opcode[3*int'(grant_idx) +: 3];
            a_source_d  = {grant_idx, req_source[10*int'(grant_idx) +: 7]};
            a_address_d = req_address[32*int'(grant_idx) +: 32];
            a_data_d    = req_data[32*int'(grant_idx) +: 32];
            a_mask_d    = req_mask[4*int'(grant_idx) +: 4];
            rr_ptr_d    = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    // Unmapped ids are sunk (d_ready=1) so a stray response cannot wedge the D channel.
    always_comb begin
        d_id        = d_source[9:7];
        d_id_ok     = int'(d_id) < NUM_REQ;
        d_ready_sel = 1'b1;
        rsp_valid   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (d_id == 3'(i)) begin
                d_ready_sel  = rsp_ready[i];
                rsp_valid[i] = d_valid && !reset;
            end
        end
        d_ready = d_ready_sel && !reset;
        d_fire  = d_valid && d_ready;
        err_d   = err_q || (d_valid && !d_id_ok);
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            if (grant && grant_idx == 3'(i) && !(d_fire && d_id == 3'(i))) begin
                if (out_cnt_q[i] != 4'hF) out_cnt_d[i] = out_cnt_q[i] + 4'd1;
            end else if (!(grant && grant_idx == 3'(i)) && d_fire && d_id == 3'(i)) begin
                if (out_cnt_q[i] != 4'h0) out_cnt_d[i] = out_cnt_q[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            a_valid_q <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            a_valid_q <= a_valid_d;
            err_q     <= err_d;
            for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= out_cnt_d[i];
        end
    end

    always_ff @(posedge clock) begin
        a_opcode_q  <= a_opcode_d;
        a_source_q  <= a_source_d;
        a_address_q <= a_address_d;
        a_data_q    <= a_data_d;
        a_mask_q    <= a_mask_d;
    end

    assign a_valid        = a_valid_q;
    assign a_opcode       = a_opcode_q;
    assign a_size         = 4'd2;
    assign a_source       = a_source_q;
    assign a_address      = a_address_q;
    assign a_data         = a_data_q;
    assign a_mask         = a_mask_q;
    assign rsp_opcode     = d_opcode;
    assign rsp_source     = {3'b000, d_source[6:0]};
    assign rsp_data       = d_data;
    assign err_bad_source = err_q;

`ifdef VX_TL_ARB_PERF_EN
    logic [31:0] perf_grants_q [NUM_REQ];
    logic [31:0] perf_stalls_q [NUM_REQ];

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                perf_grants_q[i] <= '0;
                perf_stalls_q[i] <= '0;
            end else begin
                if (req_ready[i]) perf_grants_q[i] <= perf_grants_q[i] + 32'd1;
                if (req_valid[i] && !req_ready[i]) perf_stalls_q[i] <= perf_stalls_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_grants[32*i +: 32] = perf_grants_q[i];
            perf_stalls[32*i +: 32] = perf_stalls_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_vx_tl_req_arbiter.sv
// tb/tb_vx_tl_req_arbiter.sv - scoreboard testbench for vx_tl_req_arbiter
module tb_vx_tl_req_arbiter;
    localparam int N = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset;
    logic [N-1:0]   req_valid, req_ready;
    logic [3*N-1:0] req_opcode;
    logic [10*N-1:0] req_source;
    logic [32*N-1:0] req_address, req_data;
    logic [4*N-1:0] req_mask;
    logic           a_valid, a_ready;
    logic [2:0]     a_opcode;
    logic [3:0]     a_size, a_mask;
    logic [9:0]     a_source;
    logic [31:0]    a_address, a_data;
    logic           d_valid, d_ready;
    logic [2:0]     d_opcode;
    logic [9:0]     d_source;
    logic [31:0]    d_data;
    logic [N-1:0]   rsp_valid, rsp_ready;
    logic [2:0]     rsp_opcode;
    logic [9:0]     rsp_source;
    logic [31:0]    rsp_data;
    logic           err_bad_source;
`ifdef VX_TL_ARB_PERF_EN
    logic [32*N-1:0] perf_grants, perf_stalls;
`endif

    vx_tl_req_arbiter #(.NUM_REQ(N), .MAX_OUT(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_source(req_source), .req_address(req_address), .req_data(req_data),
        .req_mask(req_mask),
        .a_valid(a_valid), .a_opcode(a_opcode), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_data(a_data), .a_mask(a_mask), .a_ready(a_ready),
        .d_valid(d_valid), .d_opcode(d_opcode), .d_source(d_source), .d_data(d_data),
        .d_ready(d_ready),
        .rsp_valid(rsp_valid), .rsp_opcode(rsp_opcode), .rsp_source(rsp_source),
        .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .err_bad_source(err_bad_source)
`ifdef VX_TL_ARB_PERF_EN
        , .perf_grants(perf_grants), .perf_stalls(perf_stalls)
`endif
    );

    typedef struct packed {
        logic [9:0]  src;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } a_txn_t;

    a_txn_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int i, input logic [7:0] tag);
        req_opcode[3*i +: 3]   = tag[2:0];
        req_source[10*i +: 10] = {3'b111, tag[6:0]};
        req_address[32*i +: 32] = 32'h8000_0000 | {24'h0, tag};
        req_data[32*i +: 32]   = {4{tag}};
        req_mask[4*i +: 4]     = tag[3:0];
    endtask

    function automatic a_txn_t exp_of(input int i, input logic [7:0] tag);
        a_txn_t t;
        t.src  = {3'(i), tag[6:0]};
        t.op   = tag[2:0];
        t.addr = 32'h8000_0000 | {24'h0, tag};
        t.data = {4{tag}};
        t.mask = tag[3:0];
        return t;
    endfunction

    task automatic d_send(input logic [9:0] src, input logic [2:0] op, input logic [31:0] data,
                          input logic [N-1:0] exp_rsp);
        d_valid = 1'b1; d_source = src; d_opcode = op; d_data = data;
        @(negedge clock);
        chk("d_rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        chk("d_ready", 64'(d_ready), 64'd1);
        chk("d_rsp_source", 64'(rsp_source), {54'd0, 3'b000, src[6:0]});
        chk("d_rsp_data", 64'(rsp_data), 64'(data));
        step();
        d_valid = 1'b0;
    endtask

    task automatic a_monitor();
        a_txn_t e;
        forever begin
            @(negedge clock);
            if (a_valid && a_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    chk("a_unexpected_fire", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("a_source", 64'(a_source), 64'(e.src));
                    chk("a_opcode", 64'(a_opcode), 64'(e.op));
                    chk("a_address", 64'(a_address), 64'(e.addr));
                    chk("a_data", 64'(a_data), 64'(e.data));
                    chk("a_mask", 64'(a_mask), 64'(e.mask));
                    chk("a_size", 64'(a_size), 64'd2);
                end
            end
        end
    endtask

    initial begin
        fork a_monitor(); join_none
        reset = 1'b1; req_valid = '1; a_ready = 1'b1; rsp_ready = '1;
        d_valid = 1'b1; d_source = '0; d_opcode = '0; d_data = '0;
        req_opcode = '0; req_source = '0; req_address = '0; req_data = '0; req_mask = '0;
        step(); step();
        @(negedge clock);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_d_ready", 64'(d_ready), 64'd0);
        step();
        reset = 1'b0; req_valid = '0; d_valid = 1'b0;
        @(negedge clock);
        chk("post_reset_a_valid", 64'(a_valid), 64'd0);
        chk("post_reset_err", 64'(err_bad_source), 64'd0);
        chk("post_reset_req_ready", 64'(req_ready), 64'd0);
        step();

        // Full-load round robin: grants 0,1,2,3,4,0.
        for (int i = 0; i < N; i++) load(i, 8'h10 + 8'(i));
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("rr_req_ready", 64'(req_ready), 64'd1 << (k % 5));
            exp_q.push_back(exp_of(k % 5, 8'h10 + 8'(k % 5)));
            step();
        end
        req_valid = '0;
        step();
        d_send({3'd0, 7'h55}, 3'd1, 32'hA000_0000, 5'b00001);
        d_send({3'd0, 7'h56}, 3'd1, 32'hA000_0001, 5'b00001);
        for (int i = 1; i < N; i++) d_send({3'(i), 7'h21}, 3'd1, 32'hB000_0000 + 32'(i), 5'b1 << i);

        // Requester 2 saturates at MAX_OUT, released by one AccessAck.
        load(2, 8'h22);
        req_valid = 5'b00100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("r2_ready_fill", 64'(req_ready), 64'b00100);
            exp_q.push_back(exp_of(2, 8'h22));
            step();
        end
        @(negedge clock);
        chk("r2_blocked_5th", 64'(req_ready), 64'd0);
        step();
        @(negedge clock);
        chk("r2_blocked_hold", 64'(req_ready), 64'd0);
        step();
        d_valid = 1'b1; d_source = 10'h100; d_opcode = 3'd0; d_data = 32'h1234_5678;
        @(negedge clock);
        chk("r2_blocked_during_d", 64'(req_ready), 64'd0);
        chk("r2_d_rsp_valid", 64'(rsp_valid), 64'b00100);
        step();
        d_valid = 1'b0;
        @(negedge clock);
        chk("r2_5th_granted", 64'(req_ready), 64'b00100);
        exp_q.push_back(exp_of(2, 8'h22));
        step();
        req_valid = '0;
        for (int k = 0; k < 4; k++) d_send({3'd2, 7'(k)}, 3'd0, 32'hC0 + 32'(k), 5'b00100);

        // Backpressure: output register holds r3 while a_ready=0.
        load(3, 8'h33); load(4, 8'h44);
        a_ready = 1'b0;
        req_valid = 5'b01000;
        @(negedge clock);
        chk("bp_first_ready", 64'(req_ready), 64'b01000);
        exp_q.push_back(exp_of(3, 8'h33));
        step();
        req_valid = 5'b10000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_a_valid", 64'(a_valid), 64'd1);
            chk("bp_a_source", 64'(a_source), {54'd0, 3'd3, 7'h33});
            chk("bp_a_address", 64'(a_address), 64'h8000_0033);
            chk("bp_a_data", 64'(a_data), 64'h3333_3333);
            step();
        end
        a_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_ready", 64'(req_ready), 64'b10000);
        exp_q.push_back(exp_of(4, 8'h44));
        step();
        req_valid = '0;
        step(); step();
        d_send({3'd3, 7'h01}, 3'd1, 32'hD3, 5'b01000);
        d_send({3'd4, 7'h02}, 3'd1, 32'hD4, 5'b10000);

        // Unmapped id 7 is sunk and flagged.
        rsp_ready = '0;
        d_valid = 1'b1; d_source = 10'h3C5; d_opcode = 3'd1;
        @(negedge clock);
        chk("bad_d_ready", 64'(d_ready), 64'd1);
        chk("bad_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("bad_err_before", 64'(err_bad_source), 64'd0);
        step();
        d_valid = 1'b0; rsp_ready = '1;
        @(negedge clock);
        chk("bad_err_set", 64'(err_bad_source), 64'd1);
        step();
        @(negedge clock);
        chk("bad_err_sticky", 64'(err_bad_source), 64'd1);
        step();

        // Simultaneous grant and completion on requester 1 at count 2.
        load(1, 8'h5A);
        req_valid = 5'b00010;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk("r1_ready_pre", 64'(req_ready), 64'b00010);
            exp_q.push_back(exp_of(1, 8'h5A));
            step();
        end
        d_valid = 1'b1; d_source = {3'd1, 7'h07}; d_opcode = 3'd1;
        @(negedge clock);
        chk("r1_same_cycle_ready", 64'(req_ready), 64'b00010);
        chk("r1_same_cycle_rsp", 64'(rsp_valid), 64'b00010);
        exp_q.push_back(exp_of(1, 8'h5A));
        step();
        d_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk("r1_ready_post", 64'(req_ready), 64'b00010);
            exp_q.push_back(exp_of(1, 8'h5A));
            step();
        end
        @(negedge clock);
        chk("r1_at_max", 64'(req_ready), 64'd0);
        step();

        // Reset with a request parked in the output register.
        load(0, 8'h66);
        a_ready = 1'b0;
        req_valid = 5'b00001;
        @(negedge clock);
        chk("mid_grant_ready", 64'(req_ready), 64'b00001);
        step();
        reset = 1'b1; a_ready = 1'b1;
        d_valid = 1'b1; d_source = 10'h000;
        @(negedge clock);
        chk("mid_reset_a_valid_held", 64'(a_valid), 64'd1);
        chk("mid_reset_req_ready", 64'(req_ready), 64'd0);
        chk("mid_reset_d_ready", 64'(d_ready), 64'd0);
        step();
        reset = 1'b0; d_valid = 1'b0; req_valid = '0;
        @(negedge clock);
        chk("after_reset_a_valid", 64'(a_valid), 64'd0);
        chk("after_reset_err", 64'(err_bad_source), 64'd0);
        step();
        for (int i = 0; i < N; i++) load(i, 8'h70 + 8'(i));
        req_valid = '1;
        @(negedge clock);
        chk("after_reset_rr_ptr", 64'(req_ready), 64'b00001);
        exp_q.push_back(exp_of(0, 8'h70));
        step();
        req_valid = 5'b00010;
        @(negedge clock);
        chk("after_reset_r1_cnt", 64'(req_ready), 64'b00010);
        exp_q.push_back(exp_of(1, 8'h71));
        step();
        req_valid = '0;

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
